// File: rtl/freqcount_precond.sv
// freqcount_precond: conditions a raw external signal ahead of a frequency counter.
// Stages: 2-flop synchronizer, optional glitch filter, edge prescaler, activity timer.
// Ports:
//   rst        async active-high reset
//   clkin      system clock
//   signal_in  raw external signal (asynchronous to clkin)
//   filt_len   glitch-filter length N (ignored when the filter is not built)
//   prescale   divide ratio 2^prescale applied to qualified edges
//   signaledge counted edge polarity, 1 = rising, 0 = falling
//   signal_out conditioned / prescaled signal for the counter
//   active     high while a qualified edge was seen in the last 65536 clocks
// Build option: define FREQPRECOND_FILTER_EN to include the glitch filter.
module freqcount_precond (
  input  logic       rst,
  input  logic       clkin,
  input  logic       signal_in,
  input  logic [3:0] filt_len,
  input  logic [2:0] prescale,
  input  logic       signaledge,
  output logic       signal_out,
  output logic       active
);

  logic        s1;
  logic        s2;
  logic        fs;
  logic        fs_last;
  logic [6:0]  pc;
  logic [6:0]  pc_next;
  logic [7:0]  pc_ext;
  logic [2:0]  pre_q;
  logic [15:0] at;
  logic        qual;
  logic        pre_chg;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= signal_in;
      s2 <= s1;
    end
  end

`ifdef FREQPRECOND_FILTER_EN
  logic [3:0] sc;

  // fs follows s2 only after s2 has differed from it for N+1 clocks.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      fs <= 1'b0;
      sc <= 4'd0;
    end else if (s2 == fs) begin
      sc <= 4'd0;
    end else if (sc == filt_len) begin
      fs <= s2;
      sc <= 4'd0;
    end else begin
      sc <= sc + 4'd1;
    end
  end
`else
  logic unused_filt;
  assign unused_filt = ^filt_len;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) fs <= 1'b0;
    else     fs <= s2;
  end
`endif

  assign qual    = signaledge ? (fs & ~fs_last) : (~fs & fs_last);
  assign pre_chg = (prescale != pre_q);

  // A prescale change restarts the divider and swallows a same-clock edge.
  always_comb begin
    pc_next = pc;
    if (pre_chg)   pc_next = 7'd0;
    else if (qual) pc_next = pc + 7'd1;
  end

  assign pc_ext = {1'b0, pc_next};

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      fs_last    <= 1'b0;
      pre_q      <= 3'd0;
      pc         <= 7'd0;
      signal_out <= 1'b0;
    end else begin
      fs_last <= fs;
      pre_q   <= prescale;
      pc      <= pc_next;
      if (prescale == 3'd0) signal_out <= fs;
      else                  signal_out <= pc_ext[prescale - 3'd1];
    end
  end

  // active drops one clock after the timer has run down to zero.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      at     <= 16'd0;
      active <= 1'b0;
    end else if (qual) begin
      at     <= 16'hFFFF;
      active <= 1'b1;
    end else if (at != 16'd0) begin
      at     <= at - 16'd1;
    end else begin
      active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freqcount_precond.sv
// tb_freqcount_precond: directed and random checks of freqcount_precond
// against a sample-history reference model.
module tb_freqcount_precond;

  logic       rst;
  logic       clkin;
  logic       signal_in;
  logic [3:0] filt_len;
  logic [2:0] prescale;
  logic       signaledge;
  logic       signal_out;
  logic       active;

`ifdef FREQPRECOND_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int NR = FILT ? 5 : 0;

  freqcount_precond dut (
    .rst        (rst),
    .clkin      (clkin),
    .signal_in  (signal_in),
    .filt_len   (filt_len),
    .prescale   (prescale),
    .signaledge (signaledge),
    .signal_out (signal_out),
    .active     (active)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference model: raw sample history, filter as an (N+1)-sample window,
  // prescaler as an edge count, activity as distance to the last edge.
  bit [31:0] shist;
  bit        mfs;
  bit        mfs_d;
  int        mcnt;
  int        mpre;
  bit        have_edge;
  longint    mk;
  longint    last_e;
  bit        m_so;
  bit        m_act;
  int        mn;
  int        mp;
  bit        mq;
  bit        mdiff;

  always @(posedge clkin or posedge rst) begin
    if (rst) begin
      shist     = '0;
      mfs       = 1'b0;
      mfs_d     = 1'b0;
      mcnt      = 0;
      mpre      = 0;
      have_edge = 1'b0;
      last_e    = 0;
      m_so      = 1'b0;
      m_act     = 1'b0;
    end else begin
      mn = FILT ? int'(filt_len) : 0;
      mp = int'(prescale);
      mq = signaledge ? (mfs && !mfs_d) : (!mfs && mfs_d);
      mdiff = 1'b1;
      for (int i = 1; i <= mn + 1; i++)
        if (shist[i] == mfs) mdiff = 1'b0;
      if (mp != mpre) mcnt = 0;
      else if (mq)    mcnt = (mcnt + 1) % 128;
      m_so = (mp == 0) ? mfs : bit'((mcnt >> (mp - 1)) & 1);
      if (mq) begin
        last_e    = mk;
        have_edge = 1'b1;
      end
      m_act = have_edge && ((mk - last_e) <= 65535);
      mfs_d = mfs;
      if (mdiff) mfs = ~mfs;
      mpre  = mp;
      shist = {shist[30:0], bit'(signal_in)};
      mk++;
    end
  end

  int n_cmp;
  int n_err;
  int tcyc;
  int r_so;
  int r_act;
  int seen;
  int hi_cnt;
  int rises;
  int falls;
  int tE;
  int tE2;
  int tgt;
  logic prev;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    @(negedge clkin);
    tcyc++;
  endtask

  task automatic step();
    tick();
    chk("signal_out", 32'(signal_out), 32'(m_so));
    chk("active", 32'(active), 32'(m_act));
  endtask

  task automatic pulse(input int hi, input int lo);
    signal_in = 1'b1;
    repeat (hi) step();
    signal_in = 1'b0;
    repeat (lo) step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    tcyc = 0;
    rst = 1'b1;
    signal_in = 1'b0;
    filt_len = 4'd0;
    prescale = 3'd0;
    signaledge = 1'b1;
    repeat (3) step();
    chk("rst_so", 32'(signal_out), 0);
    chk("rst_act", 32'(active), 0);
    rst = 1'b0;
    repeat (5) step();

    // step response, no filtering
    signal_in = 1'b1;
    r_so = 0;
    r_act = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (signal_out === 1'b1 && r_so == 0) r_so = i;
      if (active === 1'b1 && r_act == 0) r_act = i;
    end
    chk("step_lat", r_so, 4);
    chk("step_act", r_act, 4);
    signal_in = 1'b0;
    repeat (10) step();

    // glitch filter N=3
    filt_len = 4'd3;
    repeat (2) step();
    signal_in = 1'b1;
    repeat (3) step();
    signal_in = 1'b0;
    seen = 0;
    repeat (12) begin
      step();
      if (signal_out === 1'b1) seen = 1;
    end
    chk("glitch3", seen, FILT ? 0 : 1);
    repeat (5) step();
    signal_in = 1'b1;
    r_so = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 4) signal_in = 1'b0;
      if (signal_out === 1'b1 && r_so == 0) r_so = i;
    end
    chk("pulse4_lat", r_so, FILT ? 7 : 4);
    repeat (10) step();
    filt_len = 4'd0;
    repeat (2) step();

    // divide by 8: 64 edges at clkin/10
    prescale = 3'd3;
    repeat (3) step();
    hi_cnt = 0;
    rises = 0;
    falls = 0;
    prev = signal_out;
    for (int j = 0; j < 660; j++) begin
      signal_in = (j < 640) && ((j % 10) < 5);
      if (j < 640 && (j % 10) == 0 && signal_out === 1'b1) hi_cnt++;
      step();
      if (signal_out === 1'b1 && prev === 1'b0) rises++;
      if (signal_out === 1'b0 && prev === 1'b1) falls++;
      prev = signal_out;
    end
    chk("div8_rises", rises, 8);
    chk("div8_falls", falls, 8);
    chk("div8_duty", hi_cnt, 32);

    // prescale 2 -> 5 landing on an edge clock
    prescale = 3'd2;
    repeat (3) step();
    repeat (6) pulse(5, 5);
    chk("pre2_so", 32'(signal_out), 1);
    signal_in = 1'b1;
    repeat (3) step();
    prescale = 3'd5;
    step();
    chk("pc_clr", 32'(dut.pc), 0);
    chk("so_clr", 32'(signal_out), 0);
    step();
    signal_in = 1'b0;
    repeat (5) step();
    repeat (15) pulse(5, 5);
    chk("b4_lo", 32'(signal_out), 0);
    pulse(5, 5);
    chk("b4_hi", 32'(signal_out), 1);

    // random traffic
    signal_in = 1'b0;
    repeat (20) step();
    filt_len = 4'($urandom_range(0, 4));
    repeat (2) step();
    for (int s = 0; s < 150; s++) begin
      signal_in = 1'($urandom);
      if ($urandom_range(0, 7) == 0) prescale = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) signaledge = ~signaledge;
      repeat ($urandom_range(1, 12)) step();
    end

    // reset in the middle of a qualification
    signaledge = 1'b1;
    prescale = 3'd0;
    signal_in = 1'b0;
    repeat (25) step();
    signal_in = 1'b1;
    repeat (25) step();
    filt_len = 4'(NR);
    repeat (3) step();
    chk("pre_rst_so", 32'(signal_out), 1);
    chk("pre_rst_act", 32'(active), 1);
    signal_in = 1'b0;
    repeat (4) step();
`ifdef FREQPRECOND_FILTER_EN
    chk("sc_mid", 32'(dut.sc), 2);
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_async_so", 32'(signal_out), 0);
    chk("rst_async_act", 32'(active), 0);
    signal_in = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    r_so = 0;
    r_act = 0;
    tE = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (signal_out === 1'b1 && r_so == 0) r_so = i;
      if (active === 1'b1 && r_act == 0) begin
        r_act = i;
        tE = tcyc;
      end
    end
    chk("rel_lat", r_so, 4 + NR);
    chk("rel_act", r_act, 4 + NR);

    // activity timer: reload on the final decrement, then full run-out
    signal_in = 1'b0;
    repeat (20) step();
    tgt = tE + 65535 - 4 - NR;
    while (tcyc < tgt) tick();
    chk("act_pre", 32'(active), 1);
    signal_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("act_hold", 32'(active), 1);
    end
    tE2 = tE + 65535;
    while (tcyc < tE2 + 65535) tick();
    chk("act_last", 32'(active), 1);
    step();
    chk("act_drop", 32'(active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
